// File: rtl/mem_responder.sv
// Multi-cycle 16-bit data-memory responder: accepts one read/write per handshake,
// commits it LATENCY cycles later with a done pulse. Optional macro: MEM_RESP_ALIGN_CHK_EN.
module mem_responder #(
    parameter int LATENCY = 2,
    parameter int AW      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] data_out,
    output logic        err
);

    localparam int DEPTH = 1 << AW;
    localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [3:0]      cnt_reg, cnt_next;
    logic            wr_reg;
    logic [AW-1:0]   word_reg;
    logic [15:0]     wdata_reg;
    logic            mis_reg;
    logic [15:0]     data_out_reg;
    logic [15:0]     mem [DEPTH];

    logic            accept;
    logic            commit;
    logic            c_wr;
    logic [AW-1:0]   c_word;
    logic [15:0]     c_data;
    logic            c_mis;
    logic            in_mis;
    logic            unused_addr;

    assign accept      = (state_reg == IDLE) && req_valid;
    assign unused_addr = ^addr;

`ifdef MEM_RESP_ALIGN_CHK_EN
    assign in_mis = addr[0];
`else
    assign in_mis = 1'b0;
`endif

    // With LATENCY=1 the commit edge is the acceptance edge, so the live inputs
    // must be used instead of the (not yet loaded) latched request.
    always_comb begin
        if (state_reg == IDLE) begin
            c_wr   = wr;
            c_word = addr[AW:1];
            c_data = data_in;
            c_mis  = in_mis;
        end else begin
            c_wr   = wr_reg;
            c_word = word_reg;
            c_data = wdata_reg;
            c_mis  = mis_reg;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        commit     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_next = DONE;
                        commit     = 1'b1;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = DONE;
                    commit     = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            wr_reg    <= 1'b0;
            word_reg  <= '0;
            wdata_reg <= 16'h0000;
            mis_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                wr_reg    <= wr;
                word_reg  <= addr[AW:1];
                wdata_reg <= data_in;
                mis_reg   <= in_mis;
            end
        end
    end

    // Storage has no reset; the rst gate keeps a request seen during reset
    // from ever reaching the array.
    always_ff @(posedge clk) begin
        if (rst && commit && c_wr && !c_mis) begin
            mem[c_word] <= c_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out_reg <= 16'h0000;
        end else if (commit && !c_wr && !c_mis) begin
            data_out_reg <= mem[c_word];
        end
    end

    assign busy     = (state_reg != IDLE);
    assign done     = (state_reg == DONE);
    assign data_out = data_out_reg;
    assign err      = done && mis_reg;

endmodule
